uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Compile-time configuration: bit period, data width (5-9 bits), parity (none/even/odd) and 1 or 2 stop bits.
- Adds synchronous reset, parity and framing error reporting, and a break/line-low recovery path.
- Sits between the board RX pin and the command/FIFO logic, in the i_Clock domain.

Parameters:
- CLKS_PER_BIT, 434: i_Clock cycles per bit (50 MHz / 115200); legal 4..65535; counter width = $clog2(CLKS_PER_BIT).
- DATA_BITS, 8: data bits per frame; legal 5..9; sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd; value 3 is illegal (elaboration error).
- STOP_BITS, 1: number of stop bits; legal 1 or 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle pulse: frame complete, byte and flags valid.
- o_Rx_Byte  out  DATA_BITS  last received data word.
- o_Parity_Err  out  1  parity mismatch on last frame; forced 0 when PARITY_MODE = 0.
- o_Frame_Err  out  1  a stop bit sampled low on last frame.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_Reset high at a clock edge, any state):
  - state goes to IDLE; counters clear.
  - o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Busy all go to 0.
  - both synchroniser flops go to 1.
  - reset mid-frame abandons the frame with no DV.
- Synchroniser: two-flop chain on i_Rx_Serial; the FSM sees only the second flop (rx_s). Input to rx_s latency is 2 cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP.
- IDLE:
  - count = 0, bit index = 0.
  - rx_s == 0 -> START.
- START:
  - count increments until count == (CLKS_PER_BIT-1)/2.
  - at that count, if rx_s == 0: count = 0 -> DATA.
  - at that count, if rx_s == 1: glitch -> IDLE; no DV, flags unchanged.
- DATA:
  - at count == CLKS_PER_BIT-1: shift register[bit index] = rx_s, count = 0.
  - after bit DATA_BITS-1 -> PARITY when PARITY_MODE != 0, otherwise -> STOP.
- PARITY:
  - sample rx_s at count == CLKS_PER_BIT-1.
  - perr = (XOR of data bits ^ sample) != (PARITY_MODE == 2).
  - then -> STOP.
- STOP:
  - sample rx_s at count == CLKS_PER_BIT-1 for each of the STOP_BITS stop bits.
  - ferr accumulates (OR) any low sample.
  - after the last stop bit, in the same cycle:
    - o_Rx_DV = 1.
    - o_Rx_Byte, o_Parity_Err and o_Frame_Err load together.
  - then -> CLEANUP.
- CLEANUP:
  - o_Rx_DV = 0.
  - stay in CLEANUP while rx_s == 0 (break or line stuck low); -> IDLE once rx_s == 1.
  - this stops a break from being decoded as a stream of 0x00 frames.
- Output holding: o_Rx_Byte and the error flags hold until the next DV. The byte is delivered even when a framing or parity error is flagged.
- Latency: DV rises about (1 + DATA_BITS + P + STOP_BITS - 0.5) × CLKS_PER_BIT + 3 cycles after the start edge, where P = 1 when parity is enabled.
- Back-to-back frames:
  - a start edge that arrives while in CLEANUP with rx_s high is caught in IDLE on the next cycle.
  - max supported skew ±4% of the bit period.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined:
  - keep a 3-bit history of rx_s; at every sample point (start check, data, parity, stop) use the majority of the last three rx_s values.
  - the IDLE start detect still uses raw rx_s.
  - sample timing is unchanged; single-cycle glitches at a sample point are rejected.
- Undefined: single-sample rx_s; history register not built.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (3-bit).
  - PARITY_NONE/EVEN/ODD constants.
  - function for counter width.
  - shared later with uart_tx_param.
- One sub-module, uart_rx_sync: two-flop synchroniser plus the optional majority history. It outputs rx_s and rx_vote and has its own reset to 1.

Test Plan:
- Start-bit glitch: CLKS_PER_BIT=16, 8N1, 5-cycle low pulse -> no DV, FSM back in IDLE, o_Busy low within 12 cycles.
- Clean 8N1 frame: send 0xA5 -> one DV pulse, o_Rx_Byte=0xA5, both errors 0; back-to-back 0x3C follows with a second DV and 0x3C.
- Parity, even mode: PARITY_MODE=1, send 0x07 with parity bit 1 -> DV, byte 0x07, perr=0; repeat with parity 0 -> perr=1.
- Framing and break: STOP_BITS=2, second stop bit forced low -> DV with ferr=1. Line then held low 40 bit periods -> no further DV until high; next 0x55 is received correctly.
- Reset mid-frame: assert i_Reset during DATA bit 3 -> next cycle all outputs 0, state IDLE. A following 0x81 frame is received correctly.
- Majority vote (UART_RX_MAJORITY_EN defined): 0xFF with a 1-cycle low glitch on each data sample point -> byte 0xFF. Same stimulus with the macro undefined -> byte 0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and
// counter-width helper. Used by uart_rx_param and later uart_tx_param.
package uart_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_CLEANUP = 3'd5;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop RX synchroniser (resets to idle-high). With UART_RX_MAJORITY_EN
// defined, rx_vote is the 2-of-3 majority of the last three rx_s values.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Rx_Serial,
   output logic rx_s,
   output logic rx_vote
);

   logic meta_q, meta_d;
   logic rx_s_q, rx_s_d;

   always_comb begin
      meta_d = i_Rx_Serial;
      rx_s_d = meta_q;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         rx_s_q <= rx_s_d;
      end
   end

   assign rx_s = rx_s_q;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
   logic [1:0] hist_q, hist_d;

   always_comb hist_d = {hist_q[0], rx_s_q};

   always_ff @(posedge i_Clock) begin
      if (i_Reset) hist_q <= 2'b11;
      else         hist_q <= hist_d;
   end

   assign rx_vote = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign rx_vote = rx_s_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: DATA_BITS data (LSB first), optional parity,
// 1 or 2 stop bits, framing/parity flags and break hold-off in CLEANUP.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 voting at sample points.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int IW = cnt_width(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
   localparam logic          PAR_EN    = (PARITY_MODE != PARITY_NONE);
   localparam logic          PAR_ODD   = (PARITY_MODE == PARITY_ODD);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
      $error("uart_rx_param: illegal PARITY_MODE %0d", PARITY_MODE);
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_param: illegal DATA_BITS %0d", DATA_BITS);
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: illegal STOP_BITS %0d", STOP_BITS);
   end
   if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
      $error("uart_rx_param: illegal CLKS_PER_BIT %0d", CLKS_PER_BIT);
   end

   logic rx_s, rx_vote;

   uart_rx_sync u_sync (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Rx_Serial (i_Rx_Serial),
      .rx_s        (rx_s),
      .rx_vote     (rx_vote)
   );

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 dv_q, dv_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         dv_q       <= 1'b0;
         byte_q     <= '0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         dv_q       <= dv_d;
         byte_q     <= byte_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      dv_d       = 1'b0;
      byte_d     = byte_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            // Start detect deliberately uses the raw synchronised line.
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_vote) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_vote, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = PAR_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               perr_d  = ((^shift_q) ^ rx_vote) != PAR_ODD;
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               ferr_d = ferr_q | ~rx_vote;
               if (stop_idx_q == STOP_LAST) begin
                  dv_d       = 1'b1;
                  byte_d     = shift_q;
                  perr_out_d = PAR_EN & perr_q;
                  ferr_out_d = ferr_q | ~rx_vote;
                  state_d    = ST_CLEANUP;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLEANUP: begin
            // Hold here through a break so a stuck-low line is not decoded as 0x00 frames.
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_Busy       = (state_q != ST_IDLE);
      o_Rx_DV      = dv_q;
      o_Rx_Byte    = byte_q;
      o_Parity_Err = perr_out_q;
      o_Frame_Err  = ferr_out_q;
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E2 instance at
// 16 clocks/bit, checked against a per-instance expected-frame scoreboard.
module tb_uart_rx_param;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [7:0] MAJ_EXP = 8'hFF;
`else
   localparam logic [7:0] MAJ_EXP = 8'h00;
`endif

   logic clk, rst;
   logic rx_a, rx_b;
   logic dv_a, perr_a, ferr_a, busy_a;
   logic dv_b, perr_b, ferr_b, busy_b;
   logic [7:0] byte_a, byte_b;

   int checks = 0;
   int errors = 0;
   int dv_cnt_a = 0;
   int dv_cnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
      .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Busy(busy_a));

   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_b (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
      .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
      exp_t e;
      e.data = d;
      e.perr = p;
      e.ferr = f;
      return e;
   endfunction

   task automatic drive(input int which, input logic v);
      @(posedge clk);
      #1;
      if (which == 0) rx_a = v;
      else            rx_b = v;
   endtask

   // One 16-cycle bit; optional 1-cycle low glitch lined up with the sample point.
   task automatic send_bit(input int which, input logic v, input logic glitch);
      drive(which, v);
      repeat (7) @(posedge clk);
      if (glitch) begin
         drive(which, 1'b0);
         drive(which, v);
         repeat (6) @(posedge clk);
      end else begin
         repeat (8) @(posedge clk);
      end
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic par, input logic s2, input logic glitch);
      send_bit(which, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(which, d[i], glitch);
      if (which == 1) begin
         send_bit(which, par, 1'b0);
         send_bit(which, 1'b1, 1'b0);
         send_bit(which, s2, 1'b0);
      end else begin
         send_bit(which, 1'b1, 1'b0);
      end
   endtask

   task automatic wait_drain(input int which);
      for (int i = 0; i < 300; i++) begin
         if ((which == 0 ? q_a.size() : q_b.size()) == 0) break;
         @(posedge clk);
      end
      chk(which == 0 ? "a_drain" : "b_drain", which == 0 ? q_a.size() : q_b.size(), 0);
   endtask

   initial begin : mon_a
      exp_t e;
      forever begin
         @(negedge clk);
         if (dv_a) begin
            dv_cnt_a++;
            if (q_a.size() == 0) chk("a_dv_unexpected", q_a.size(), 1);
            else begin
               e = q_a.pop_front();
               chk("a_byte", 32'(byte_a), 32'(e.data));
               chk("a_perr", 32'(perr_a), 32'(e.perr));
               chk("a_ferr", 32'(ferr_a), 32'(e.ferr));
            end
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (dv_b) begin
            dv_cnt_b++;
            if (q_b.size() == 0) chk("b_dv_unexpected", q_b.size(), 1);
            else begin
               e = q_b.pop_front();
               chk("b_byte", 32'(byte_b), 32'(e.data));
               chk("b_perr", 32'(perr_b), 32'(e.perr));
               chk("b_ferr", 32'(ferr_b), 32'(e.ferr));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int saved;
      rx_a = 1'b1;
      rx_b = 1'b1;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_dv", 32'(dv_a), 0);
      chk("rst_a_byte", 32'(byte_a), 0);
      chk("rst_a_perr", 32'(perr_a), 0);
      chk("rst_a_ferr", 32'(ferr_a), 0);
      chk("rst_a_busy", 32'(busy_a), 0);
      chk("rst_b_dv", 32'(dv_b), 0);
      chk("rst_b_byte", 32'(byte_b), 0);
      chk("rst_b_perr", 32'(perr_b), 0);
      chk("rst_b_ferr", 32'(ferr_b), 0);
      chk("rst_b_busy", 32'(busy_b), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);

      // 5-cycle low pulse: START check finds the line high again.
      saved = dv_cnt_a;
      drive(0, 1'b0);
      repeat (4) @(posedge clk);
      drive(0, 1'b1);
      @(negedge clk);
      chk("glitch_busy_mid", 32'(busy_a), 1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_low", 32'(busy_a), 0);
      repeat (40) @(posedge clk);
      chk("glitch_no_dv", dv_cnt_a, saved);

      // Clean 8N1 frames, back to back.
      saved = dv_cnt_a;
      q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
      q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
      send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      wait_drain(0);
      chk("b2b_dv_count", dv_cnt_a, saved + 2);

      // Reset during data bit 3 (0x2A bit 3 is 1, so the line stays high afterwards).
      saved = dv_cnt_a;
      send_bit(0, 1'b0, 1'b0);
      send_bit(0, 1'b0, 1'b0);
      send_bit(0, 1'b1, 1'b0);
      send_bit(0, 1'b0, 1'b0);
      drive(0, 1'b1);
      repeat (7) @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_dv", 32'(dv_a), 0);
      chk("midrst_byte", 32'(byte_a), 0);
      chk("midrst_perr", 32'(perr_a), 0);
      chk("midrst_ferr", 32'(ferr_a), 0);
      chk("midrst_busy", 32'(busy_a), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (64) @(posedge clk);
      chk("midrst_no_dv", dv_cnt_a, saved);
      q_a.push_back(mk(8'h81, 1'b0, 1'b0));
      send(0, 8'h81, 1'b0, 1'b1, 1'b0);
      wait_drain(0);

      // Even parity: 0x07 has three ones, so the correct parity bit is 1.
      q_b.push_back(mk(8'h07, 1'b0, 1'b0));
      send(1, 8'h07, 1'b1, 1'b1, 1'b0);
      q_b.push_back(mk(8'h07, 1'b1, 1'b0));
      send(1, 8'h07, 1'b0, 1'b1, 1'b0);
      wait_drain(1);

      // Second stop bit low, then the line stays low for 40 bit periods.
      saved = dv_cnt_b;
      q_b.push_back(mk(8'h5A, 1'b0, 1'b1));
      send(1, 8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (640) @(posedge clk);
      chk("break_single_dv", dv_cnt_b, saved + 1);
      drive(1, 1'b1);
      repeat (32) @(posedge clk);
      q_b.push_back(mk(8'h55, 1'b0, 1'b0));
      send(1, 8'h55, 1'b0, 1'b1, 1'b0);
      wait_drain(1);

      // 0xFF with a 1-cycle low glitch on every data sample point.
      repeat (20) @(posedge clk);
      saved = dv_cnt_a;
      q_a.push_back(mk(MAJ_EXP, 1'b0, 1'b0));
      send(0, 8'hFF, 1'b0, 1'b1, 1'b1);
      wait_drain(0);
      chk("maj_dv_count", dv_cnt_a, saved + 1);

      repeat (20) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
